// File: rtl/alu_pkg.sv
// ============================================================================
// Module      : alu_pkg
// Description : Shared ALU-control encodings (aluop classes, R-type funct
//               codes, 2-bit operation codes) and the control bundle type.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam logic [2:0] C_ALUOP_ADD   = 3'b000;
  localparam logic [2:0] C_ALUOP_SUB   = 3'b001;
  localparam logic [2:0] C_ALUOP_FUNCT = 3'b010;
  localparam logic [2:0] C_ALUOP_SLT   = 3'b011;
  localparam logic [2:0] C_ALUOP_AND   = 3'b100;
  localparam logic [2:0] C_ALUOP_OR    = 3'b101;

  localparam logic [5:0] C_FUNCT_ADD = 6'h20;
  localparam logic [5:0] C_FUNCT_SUB = 6'h22;
  localparam logic [5:0] C_FUNCT_AND = 6'h24;
  localparam logic [5:0] C_FUNCT_OR  = 6'h25;
  localparam logic [5:0] C_FUNCT_NOR = 6'h27;
  localparam logic [5:0] C_FUNCT_SLT = 6'h2A;

  localparam logic [1:0] C_OP_AND = 2'b00;
  localparam logic [1:0] C_OP_OR  = 2'b01;
  localparam logic [1:0] C_OP_ADD = 2'b10;
  localparam logic [1:0] C_OP_SLT = 2'b11;

  typedef struct packed {
    logic       a_invert;
    logic       b_invert;
    logic       cin;
    logic [1:0] operation;
  } alu_ctrl_t;

  function automatic alu_ctrl_t mk_ctrl(input logic a_inv, input logic b_inv,
                                        input logic cin, input logic [1:0] op);
    alu_ctrl_t c;
    c.a_invert  = a_inv;
    c.b_invert  = b_inv;
    c.cin       = cin;
    c.operation = op;
    return c;
  endfunction

  // Subtraction-style ops invert B and inject a carry to form two's complement.
  localparam alu_ctrl_t C_CTRL_ADD = '{1'b0, 1'b0, 1'b0, C_OP_ADD};
  localparam alu_ctrl_t C_CTRL_SUB = '{1'b0, 1'b1, 1'b1, C_OP_ADD};
  localparam alu_ctrl_t C_CTRL_AND = '{1'b0, 1'b0, 1'b0, C_OP_AND};
  localparam alu_ctrl_t C_CTRL_OR  = '{1'b0, 1'b0, 1'b0, C_OP_OR};
  localparam alu_ctrl_t C_CTRL_NOR = '{1'b1, 1'b1, 1'b0, C_OP_AND};
  localparam alu_ctrl_t C_CTRL_SLT = '{1'b0, 1'b1, 1'b1, C_OP_SLT};

endpackage

`default_nettype wire

// File: rtl/alu_ctrl_decode.sv
// ============================================================================
// Module      : alu_ctrl_decode
// Description : Combinational aluop/funct decode to per-bit ALU controls
//               plus an illegal-encoding flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [2:0] i_aluop,
  input  logic [5:0] i_funct,
  output alu_ctrl_t  o_ctrl,
  output logic       o_illegal
);

  // Illegal encodings fall back to add controls so the datapath stays benign.
  always_comb begin
    o_ctrl    = mk_ctrl(1'b0, 1'b0, 1'b0, C_OP_ADD);
    o_illegal = 1'b0;
    case (i_aluop)
      C_ALUOP_ADD: o_ctrl = C_CTRL_ADD;
      C_ALUOP_SUB: o_ctrl = C_CTRL_SUB;
      C_ALUOP_SLT: o_ctrl = C_CTRL_SLT;
      C_ALUOP_AND: o_ctrl = C_CTRL_AND;
      C_ALUOP_OR:  o_ctrl = C_CTRL_OR;
      C_ALUOP_FUNCT: begin
        case (i_funct)
          C_FUNCT_ADD: o_ctrl = C_CTRL_ADD;
          C_FUNCT_SUB: o_ctrl = C_CTRL_SUB;
          C_FUNCT_AND: o_ctrl = C_CTRL_AND;
          C_FUNCT_OR:  o_ctrl = C_CTRL_OR;
          C_FUNCT_NOR: o_ctrl = C_CTRL_NOR;
          C_FUNCT_SLT: o_ctrl = C_CTRL_SLT;
          default:     o_illegal = 1'b1;
        endcase
      end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu_ctrl_stage.sv
// ============================================================================
// Module      : alu_ctrl_stage
// Description : ALU-control pipeline stage: decodes op class/funct and
//               registers operands and controls with stall/flush handling.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_ctrl_stage
  import alu_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        valid_i,
  input  logic [2:0]  aluop_i,
  input  logic [5:0]  funct_i,
  input  logic [31:0] rs_data_i,
  input  logic [31:0] rt_data_i,
  input  logic [31:0] imm_i,
  input  logic        alusrc_i,
  input  logic        regwrite_i,
  input  logic [4:0]  rd_addr_i,
  output logic [31:0] src1_o,
  output logic [31:0] src2_o,
  output logic        a_invert_o,
  output logic        b_invert_o,
  output logic        cin_o,
  output logic [1:0]  operation_o,
  output logic        valid_o,
  output logic        regwrite_o,
  output logic [4:0]  rd_addr_o,
  output logic        illegal_o,
  output logic        illegal_sticky_o
);

  alu_ctrl_t   w_ctrl;
  logic        w_illegal;

  logic [31:0] r_src1;
  logic [31:0] r_src2;
  alu_ctrl_t   r_ctrl;
  logic        r_valid;
  logic        r_regwrite;
  logic [4:0]  r_rd_addr;
  logic        r_illegal;
  logic        r_sticky;

  alu_ctrl_decode u_decode (
    .i_aluop   (aluop_i),
    .i_funct   (funct_i),
    .o_ctrl    (w_ctrl),
    .o_illegal (w_illegal)
  );

  // Flush dominates stall; an idle (invalid, unstalled) slot also becomes a bubble.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_src1     <= '0;
      r_src2     <= '0;
      r_ctrl     <= C_CTRL_AND;
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
      r_rd_addr  <= '0;
      r_illegal  <= 1'b0;
      r_sticky   <= 1'b0;
    end else if (flush_i || (!stall_i && !valid_i)) begin
      r_src1     <= '0;
      r_src2     <= '0;
      r_ctrl     <= C_CTRL_AND;
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
      r_rd_addr  <= '0;
      r_illegal  <= 1'b0;
    end else if (stall_i) begin
      r_illegal  <= 1'b0;
    end else begin
      r_src1     <= rs_data_i;
      r_src2     <= alusrc_i ? imm_i : rt_data_i;
      r_ctrl     <= w_ctrl;
      r_valid    <= 1'b1;
      r_regwrite <= regwrite_i && !w_illegal;
      r_rd_addr  <= rd_addr_i;
      r_illegal  <= w_illegal;
      r_sticky   <= r_sticky || w_illegal;
    end
  end

  assign src1_o           = r_src1;
  assign src2_o           = r_src2;
  assign a_invert_o       = r_ctrl.a_invert;
  assign b_invert_o       = r_ctrl.b_invert;
  assign cin_o            = r_ctrl.cin;
  assign operation_o      = r_ctrl.operation;
  assign valid_o          = r_valid;
  assign regwrite_o       = r_regwrite;
  assign rd_addr_o        = r_rd_addr;
  assign illegal_o        = r_illegal;
  assign illegal_sticky_o = r_sticky;

endmodule

`default_nettype wire

// File: tb/tb_alu_ctrl_stage.sv
// ============================================================================
// Module      : tb_alu_ctrl_stage
// Description : Self-checking bench for alu_ctrl_stage against a
//               behavioural model of the stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_ctrl_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush, valid, alusrc, regwrite;
  logic [2:0]  aluop;
  logic [5:0]  funct;
  logic [31:0] rs_data, rt_data, imm;
  logic [4:0]  rd_addr;
  logic [31:0] src1_o, src2_o;
  logic        a_inv_o, b_inv_o, cin_o, valid_o, regwrite_o, illegal_o, sticky_o;
  logic [1:0]  op_o;
  logic [4:0]  rd_o;

  int checks = 0;
  int errors = 0;

  // Expected outputs
  logic [31:0] e_src1, e_src2;
  logic [4:0]  e_ctrl;
  logic        e_valid, e_rw, e_ill, e_sticky;
  logic [4:0]  e_rd;

  // {a_invert, b_invert, cin, operation} for add, sub, and, or, nor, slt
  logic [4:0]  ctrl_tab [6];
  logic [5:0]  legal_funct [6];

  always #5 clk = ~clk;

  alu_ctrl_stage dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .stall_i          (stall),
    .flush_i          (flush),
    .valid_i          (valid),
    .aluop_i          (aluop),
    .funct_i          (funct),
    .rs_data_i        (rs_data),
    .rt_data_i        (rt_data),
    .imm_i            (imm),
    .alusrc_i         (alusrc),
    .regwrite_i       (regwrite),
    .rd_addr_i        (rd_addr),
    .src1_o           (src1_o),
    .src2_o           (src2_o),
    .a_invert_o       (a_inv_o),
    .b_invert_o       (b_inv_o),
    .cin_o            (cin_o),
    .operation_o      (op_o),
    .valid_o          (valid_o),
    .regwrite_o       (regwrite_o),
    .rd_addr_o        (rd_o),
    .illegal_o        (illegal_o),
    .illegal_sticky_o (sticky_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Operation class index into ctrl_tab: 0 add,1 sub,2 and,3 or,4 nor,5 slt; -1 illegal
  function automatic int op_class(input logic [2:0] a, input logic [5:0] f);
    case (a)
      3'd0: return 0;
      3'd1: return 1;
      3'd3: return 5;
      3'd4: return 2;
      3'd5: return 3;
      3'd2: begin
        case (f)
          6'h20: return 0;
          6'h22: return 1;
          6'h24: return 2;
          6'h25: return 3;
          6'h27: return 4;
          6'h2A: return 5;
          default: return -1;
        endcase
      end
      default: return -1;
    endcase
  endfunction

  task automatic model_bubble();
    e_src1 = 0; e_src2 = 0; e_ctrl = 5'b00000;
    e_valid = 0; e_rw = 0; e_rd = 0; e_ill = 0;
  endtask

  task automatic model_edge();
    int cls;
    if (flush) model_bubble();
    else if (stall) e_ill = 0;
    else if (!valid) model_bubble();
    else begin
      cls     = op_class(aluop, funct);
      e_src1  = rs_data;
      e_src2  = alusrc ? imm : rt_data;
      e_ctrl  = (cls < 0) ? ctrl_tab[0] : ctrl_tab[cls];
      e_valid = 1;
      e_rw    = regwrite && (cls >= 0);
      e_rd    = rd_addr;
      e_ill   = (cls < 0);
      if (cls < 0) e_sticky = 1;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_src1"},   src1_o, e_src1);
    check({tag, "_src2"},   src2_o, e_src2);
    check({tag, "_ctrl"},   {27'd0, a_inv_o, b_inv_o, cin_o, op_o}, {27'd0, e_ctrl});
    check({tag, "_valid"},  {31'd0, valid_o}, {31'd0, e_valid});
    check({tag, "_rw"},     {31'd0, regwrite_o}, {31'd0, e_rw});
    check({tag, "_rd"},     {27'd0, rd_o}, {27'd0, e_rd});
    check({tag, "_ill"},    {31'd0, illegal_o}, {31'd0, e_ill});
    check({tag, "_sticky"}, {31'd0, sticky_o}, {31'd0, e_sticky});
  endtask

  // Inputs are set by the caller; the model sees them before the edge.
  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic set_instr(input logic [2:0] a, input logic [5:0] f, input logic [31:0] rs,
                           input logic [31:0] rt, input logic [31:0] im, input logic src,
                           input logic rw, input logic [4:0] rd);
    valid = 1; stall = 0; flush = 0;
    aluop = a; funct = f; rs_data = rs; rt_data = rt; imm = im;
    alusrc = src; regwrite = rw; rd_addr = rd;
  endtask

  task automatic randomize_inputs();
    stall    = ($urandom_range(0, 3) == 0);
    flush    = ($urandom_range(0, 7) == 0);
    valid    = ($urandom_range(0, 3) != 0);
    aluop    = 3'($urandom_range(0, 7));
    funct    = $urandom_range(0, 1) ? legal_funct[$urandom_range(0, 5)] : 6'($urandom);
    rs_data  = $urandom;
    rt_data  = $urandom;
    imm      = $urandom;
    alusrc   = 1'($urandom);
    regwrite = 1'($urandom);
    rd_addr  = 5'($urandom);
  endtask

  initial begin
    ctrl_tab[0] = 5'b00010; ctrl_tab[1] = 5'b01110; ctrl_tab[2] = 5'b00000;
    ctrl_tab[3] = 5'b00001; ctrl_tab[4] = 5'b11000; ctrl_tab[5] = 5'b01111;
    legal_funct[0] = 6'h20; legal_funct[1] = 6'h22; legal_funct[2] = 6'h24;
    legal_funct[3] = 6'h25; legal_funct[4] = 6'h27; legal_funct[5] = 6'h2A;

    rst = 1; stall = 0; flush = 0; valid = 0; alusrc = 0; regwrite = 0;
    aluop = 0; funct = 0; rs_data = 0; rt_data = 0; imm = 0; rd_addr = 0;
    model_bubble(); e_sticky = 0;
    #2;
    check_all("reset");
    @(negedge clk);
    rst = 0;

    // sub via funct
    set_instr(3'b010, 6'h22, 32'd5, 32'd3, 32'd0, 1'b0, 1'b1, 5'd7);
    step("sub");
    check("sub_ctrl_lit", {27'd0, a_inv_o, b_inv_o, cin_o, op_o}, 32'b01110);
    check("sub_src2_lit", src2_o, 32'd3);

    // add with immediate
    set_instr(3'b000, 6'h00, 32'd100, 32'd9, 32'hFFFF_FFFC, 1'b1, 1'b1, 5'd3);
    step("addi");
    check("addi_src2_lit", src2_o, 32'hFFFF_FFFC);

    // slt captured then held over three stalled cycles with changing inputs
    set_instr(3'b011, 6'h00, 32'd1, 32'd2, 32'd0, 1'b0, 1'b1, 5'd9);
    step("slt");
    for (int i = 0; i < 3; i++) begin
      randomize_inputs();
      stall = 1; flush = 0;
      step("stall");
      check("stall_slt_lit", {27'd0, a_inv_o, b_inv_o, cin_o, op_o}, 32'b01111);
    end

    // stall and flush together
    set_instr(3'b001, 6'h00, 32'd4, 32'd4, 32'd0, 1'b0, 1'b1, 5'd2);
    stall = 1; flush = 1;
    step("stall_flush");
    check("stall_flush_valid_lit", {31'd0, valid_o}, 32'd0);

    // illegal funct: pulse then sticky persists through bubbles and flush
    set_instr(3'b010, 6'h3F, 32'd8, 32'd1, 32'd0, 1'b0, 1'b1, 5'd11);
    step("illegal");
    check("illegal_pulse_lit", {31'd0, illegal_o}, 32'd1);
    check("illegal_rw_lit", {31'd0, regwrite_o}, 32'd0);
    set_instr(3'b100, 6'h00, 32'd8, 32'd1, 32'd0, 1'b0, 1'b1, 5'd12);
    step("after_illegal");
    check("illegal_deassert_lit", {31'd0, illegal_o}, 32'd0);
    flush = 1;
    step("flush_keeps_sticky");
    check("sticky_lit", {31'd0, sticky_o}, 32'd1);

    // illegal aluop
    set_instr(3'b111, 6'h20, 32'd6, 32'd6, 32'd0, 1'b0, 1'b1, 5'd13);
    step("illegal_aluop");

    for (int i = 0; i < 400; i++) begin
      randomize_inputs();
      step("rand");
    end

    // async reset mid-stall, between edges
    set_instr(3'b101, 6'h00, 32'h1234, 32'h55, 32'd0, 1'b0, 1'b1, 5'd17);
    step("pre_rst");
    stall = 1;
    #2;
    rst = 1;
    #1;
    model_bubble(); e_sticky = 0;
    check_all("async_rst");
    #2;
    rst = 0;
    set_instr(3'b000, 6'h00, 32'd21, 32'd21, 32'd0, 1'b0, 1'b1, 5'd1);
    step("post_rst");

    for (int i = 0; i < 200; i++) begin
      randomize_inputs();
      step("rand2");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_ctrl_stage.md
ALU_CTRL_STAGE -- requirements
Module: alu_ctrl_stage

Interface
REQ-001 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port stall_i  input  1  hold stage contents.
REQ-004 SHALL have port flush_i  input  1  replace next stage contents with bubble.
REQ-005 SHALL have port valid_i  input  1  upstream instruction valid.
REQ-006 SHALL have port aluop_i  input  3  main-decoder ALU op class.
REQ-007 SHALL have port funct_i  input  6  R-type funct field.
REQ-008 SHALL have ports rs_data_i, rt_data_i, imm_i  input  32 each  operands / sign-extended immediate.
REQ-009 SHALL have ports alusrc_i  input  1 (1 = imm_i as src2), regwrite_i  input  1, rd_addr_i  input  5.
REQ-010 SHALL have outputs src1_o, src2_o  32 each  registered ALU operands.
REQ-011 SHALL have outputs a_invert_o, b_invert_o, cin_o  1 each, operation_o  2  registered per-bit ALU controls.
REQ-012 SHALL have outputs valid_o  1, regwrite_o  1, rd_addr_o  5, illegal_o  1 (one-cycle pulse), illegal_sticky_o  1.

Function
REQ-013 SHALL decode combinationally, then register, giving exactly one cycle latency from input to outputs.
REQ-014 SHALL decode aluop_i: 000 add; 001 sub; 010 use funct_i; 011 slt; 100 and; 101 or; 110/111 illegal.
REQ-015 SHALL decode funct_i (aluop 010): 0x20 add; 0x22 sub; 0x24 and; 0x25 or; 0x27 nor; 0x2A slt; any other illegal.
REQ-016 SHALL map {a_invert,b_invert,cin,operation}: add 0,0,0,10; sub 0,1,1,10; and 0,0,0,00; or 0,0,0,01; nor 1,1,0,00; slt 0,1,1,11.
REQ-017 SHALL drive src1_o = rs_data_i, src2_o = alusrc_i ? imm_i : rt_data_i at capture.
REQ-018 SHALL on illegal decode with valid_i=1: capture as add controls, force regwrite_o=0, keep valid_o=1, pulse illegal_o for that one output cycle, set illegal_sticky_o.
REQ-019 SHALL with stall_i=1, flush_i=0: hold every output register unchanged; illegal_o deasserts after its single cycle.
REQ-020 SHALL with flush_i=1 (regardless of stall_i): load bubble -- valid_o=0, regwrite_o=0, rd_addr_o=0, controls=and (0,0,0,00), operands=0, illegal_o=0.
REQ-021 SHALL with valid_i=0 and no stall: load bubble as REQ-020.
REQ-022 SHALL force regwrite_o=0 whenever valid_o=0.
REQ-023 SHALL keep illegal_sticky_o set until reset; flush does not clear it.

Reset
REQ-024 SHALL on rst_i=1 immediately clear all outputs to 0 (bubble per REQ-020, illegal_sticky_o=0), independent of clk_i.
REQ-025 SHALL resume capture on the first rising edge after rst_i deasserts; reset mid-stall discards held instruction.

Structure
REQ-026 SHALL place aluop encodings, funct constants, and the 2-bit operation codes (AND=00, OR=01, ADD=10, SLT=11) in shared package alu_pkg.
REQ-027 SHALL contain one sub-module alu_ctrl_decode (combinational aluop/funct to controls + illegal flag); pipeline register in top.

Verification
REQ-028 SHALL test: aluop=010, funct=0x22, rs=5, rt=3, valid=1 -> next cycle src1=5, src2=3, b_inv=1, cin=1, op=10, valid_o=1.
REQ-029 SHALL test: aluop=000, alusrc=1, imm=0xFFFFFFFC -> src2_o=0xFFFFFFFC, op=10, inverts/cin=0.
REQ-030 SHALL test: capture slt, then stall_i=1 three cycles with changing inputs -> outputs stay slt (0,1,1,11) all three cycles.
REQ-031 SHALL test: stall_i=1 and flush_i=1 same cycle -> valid_o=0, regwrite_o=0 next cycle.
REQ-032 SHALL test: aluop=010, funct=0x3F, regwrite_i=1 -> valid_o=1, regwrite_o=0, illegal_o one-cycle pulse, illegal_sticky_o=1 until rst_i.
REQ-033 SHALL test: assert rst_i between clock edges mid-stream -> all outputs 0 before the next edge.
